// File: rtl/led_chaser_if.sv
// Control and drive bundle between the LED chaser and its user.
// The master sets enable/mode/speed; the slave (chaser) drives LED, pos and step.
interface led_chaser_if #(
  parameter int unsigned NUM_LEDS = 16
) ();
  localparam int unsigned POS_W = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;

  logic                enable;
  logic [1:0]          mode;
  logic [1:0]          speed;
  logic [NUM_LEDS-1:0] LED;
  logic [POS_W-1:0]    pos;
  logic                step;

  modport master (output enable, mode, speed, input LED, pos, step);
  modport slave  (input enable, mode, speed, output LED, pos, step);
endinterface

// File: rtl/led_chaser.sv
// One-hot LED chaser with a run-time selectable step rate and
// up / down / bounce / blink-all modes; exports a one-cycle step pulse.
module led_chaser #(
  parameter int unsigned NUM_LEDS    = 16,
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned STEP_MS     = 1000
) (
  input  logic         clk,
  input  logic         rst,
  led_chaser_if.slave  bus
);

  localparam int unsigned BASE_COUNT = CLK_FREQ_HZ / 1000 * STEP_MS;
  localparam int unsigned CNT_W      = $clog2(BASE_COUNT);
  localparam int unsigned POS_W      = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] PREV_POS = POS_W'(NUM_LEDS - 2);

  if (BASE_COUNT < 8) begin : g_bad_base_count
    $error("led_chaser: BASE_COUNT must be at least 8");
  end
  if (NUM_LEDS < 2 || NUM_LEDS > 64) begin : g_bad_num_leds
    $error("led_chaser: NUM_LEDS must be in 2..64");
  end

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [POS_W-1:0]    pos, pos_n;
  logic                dir, dir_n;
  logic                blink_on, blink_n;
  logic [NUM_LEDS-1:0] led, led_n;
  logic                step;
  logic [CNT_W-1:0]    period_m1_c;
  logic                tick_c;
  mode_e               mode_c;

  assign mode_c = mode_e'(bus.mode);

  // Compare limit P-1 for the selected rate; >= lets a shortened period tick at once
  always_comb begin
    period_m1_c = CNT_W'(BASE_COUNT - 1);
    case (bus.speed)
      2'd1:    period_m1_c = CNT_W'((BASE_COUNT >> 1) - 1);
      2'd2:    period_m1_c = CNT_W'((BASE_COUNT >> 2) - 1);
      2'd3:    period_m1_c = CNT_W'((BASE_COUNT >> 3) - 1);
      default: period_m1_c = CNT_W'(BASE_COUNT - 1);
    endcase
  end

  assign tick_c = bus.enable && (cnt >= period_m1_c);

  // Next-state: prescaler, position/direction walk, blink phase and LED image
  always_comb begin
    cnt_n   = cnt;
    pos_n   = pos;
    dir_n   = dir;
    blink_n = blink_on;
    led_n   = '0;

    if (tick_c)          cnt_n = '0;
    else if (bus.enable) cnt_n = cnt + 1'b1;

    if (tick_c) begin
      case (mode_c)
        MODE_UP: begin
          pos_n = (pos == LAST_POS) ? '0 : pos + 1'b1;
          dir_n = 1'b0;
        end
        MODE_DOWN: begin
          pos_n = (pos == '0) ? LAST_POS : pos - 1'b1;
          dir_n = 1'b1;
        end
        MODE_BOUNCE: begin
          if (!dir) begin
            if (pos == LAST_POS) begin
              dir_n = 1'b1;
              pos_n = PREV_POS;
            end else begin
              pos_n = pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              dir_n = 1'b0;
              pos_n = POS_W'(1);
            end else begin
              pos_n = pos - 1'b1;
            end
          end
        end
        default: blink_n = ~blink_on;
      endcase
    end

    // Held high outside BLINK so entering BLINK always shows all-on first
    if (mode_c != MODE_BLINK) blink_n = 1'b1;

    if (mode_c == MODE_BLINK) led_n = {NUM_LEDS{blink_n}};
    else                      led_n = NUM_LEDS'(1) << pos_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      pos      <= '0;
      dir      <= 1'b0;
      blink_on <= 1'b1;
      led      <= NUM_LEDS'(1);
      step     <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      pos      <= pos_n;
      dir      <= dir_n;
      blink_on <= blink_n;
      led      <= led_n;
      step     <= tick_c;
    end
  end

  assign bus.LED  = led;
  assign bus.pos  = pos;
  assign bus.step = step;

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser with NUM_LEDS=4 and BASE_COUNT=8.
module tb_led_chaser;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  led_chaser_if #(.NUM_LEDS(4)) bus ();

  led_chaser #(
    .NUM_LEDS   (4),
    .CLK_FREQ_HZ(8000),
    .STEP_MS    (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [1:0] s);
    bus.enable = 1'b1;
    bus.mode   = m;
    bus.speed  = s;
    rst        = 1'b1;
    cyc();
    rst        = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'd0, 2'd0);
    checks++; if (bus.LED !== 4'b0001) $display("FAIL reset_led got %b exp 0001", bus.LED); else passes++;
    checks++; if (bus.pos !== 2'd0) $display("FAIL reset_pos got %0d exp 0", bus.pos); else passes++;
    checks++; if (bus.step !== 1'b0) $display("FAIL reset_step got %b exp 0", bus.step); else passes++;
  endtask

  task automatic test_up();
    logic [3:0] exp_led [4];
    logic [1:0] exp_pos [4];
    logic [3:0] prev;
    exp_led = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_pos = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset(2'd0, 2'd0);
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 7; k++) begin
        cyc();
        checks++; if (bus.step !== 1'b0 || bus.LED !== prev)
          $display("FAIL up_hold[%0d.%0d] got step=%b led=%b exp step=0 led=%b", i, k, bus.step, bus.LED, prev);
        else passes++;
      end
      cyc();
      checks++; if (bus.LED !== exp_led[i] || bus.pos !== exp_pos[i] || bus.step !== 1'b1)
        $display("FAIL up_tick[%0d] got led=%b pos=%0d step=%b exp led=%b pos=%0d step=1",
                 i, bus.LED, bus.pos, bus.step, exp_led[i], exp_pos[i]);
      else passes++;
      prev = exp_led[i];
    end
  endtask

  task automatic test_down();
    logic [3:0] exp_led [5];
    logic [3:0] prev;
    exp_led = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    do_reset(2'd1, 2'd2);
    prev = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (bus.step !== 1'b0 || bus.LED !== prev)
        $display("FAIL down_hold[%0d] got step=%b led=%b exp step=0 led=%b", i, bus.step, bus.LED, prev);
      else passes++;
      cyc();
      checks++; if (bus.LED !== exp_led[i] || bus.step !== 1'b1)
        $display("FAIL down_tick[%0d] got led=%b step=%b exp led=%b step=1", i, bus.LED, bus.step, exp_led[i]);
      else passes++;
      prev = exp_led[i];
    end
  endtask

  task automatic test_bounce();
    logic [1:0] exp_pos [8];
    logic [3:0] exp_led;
    exp_pos = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
    do_reset(2'd2, 2'd3);
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp_led = 4'b0001 << exp_pos[i];
      checks++; if (bus.pos !== exp_pos[i] || bus.LED !== exp_led || bus.step !== 1'b1)
        $display("FAIL bounce[%0d] got pos=%0d led=%b step=%b exp pos=%0d led=%b step=1",
                 i, bus.pos, bus.LED, bus.step, exp_pos[i], exp_led);
      else passes++;
    end
  endtask

  task automatic test_blink();
    do_reset(2'd0, 2'd0);
    repeat (8) cyc();
    checks++; if (bus.LED !== 4'b0010) $display("FAIL blink_pre got %b exp 0010", bus.LED); else passes++;
    bus.mode = 2'd3;
    cyc();
    checks++; if (bus.LED !== 4'b1111 || bus.pos !== 2'd1)
      $display("FAIL blink_enter got led=%b pos=%0d exp led=1111 pos=1", bus.LED, bus.pos);
    else passes++;
    repeat (6) cyc();
    checks++; if (bus.LED !== 4'b1111) $display("FAIL blink_hold got %b exp 1111", bus.LED); else passes++;
    cyc();
    checks++; if (bus.LED !== 4'b0000 || bus.step !== 1'b1 || bus.pos !== 2'd1)
      $display("FAIL blink_off got led=%b step=%b pos=%0d exp led=0000 step=1 pos=1", bus.LED, bus.step, bus.pos);
    else passes++;
    repeat (8) cyc();
    checks++; if (bus.LED !== 4'b1111 || bus.pos !== 2'd1)
      $display("FAIL blink_on got led=%b pos=%0d exp led=1111 pos=1", bus.LED, bus.pos);
    else passes++;
    bus.mode = 2'd0;
    cyc();
    checks++; if (bus.LED !== 4'b0010 || bus.step !== 1'b0)
      $display("FAIL blink_exit got led=%b step=%b exp led=0010 step=0", bus.LED, bus.step);
    else passes++;
  endtask

  task automatic test_freeze();
    do_reset(2'd0, 2'd0);
    repeat (5) cyc();
    bus.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++; if (bus.step !== 1'b0 || bus.LED !== 4'b0001)
        $display("FAIL freeze[%0d] got step=%b led=%b exp step=0 led=0001", k, bus.step, bus.LED);
      else passes++;
    end
    bus.enable = 1'b1;
    repeat (2) cyc();
    checks++; if (bus.step !== 1'b0 || bus.LED !== 4'b0001)
      $display("FAIL resume_early got step=%b led=%b exp step=0 led=0001", bus.step, bus.LED);
    else passes++;
    cyc();
    checks++; if (bus.step !== 1'b1 || bus.LED !== 4'b0010)
      $display("FAIL resume_tick got step=%b led=%b exp step=1 led=0010", bus.step, bus.LED);
    else passes++;
  endtask

  task automatic test_speed_change();
    do_reset(2'd0, 2'd0);
    repeat (5) cyc();
    bus.speed = 2'd2;
    cyc();
    checks++; if (bus.step !== 1'b1 || bus.LED !== 4'b0010)
      $display("FAIL speed_drop got step=%b led=%b exp step=1 led=0010", bus.step, bus.LED);
    else passes++;
    bus.speed = 2'd0;
  endtask

  task automatic test_reset_on_tick();
    do_reset(2'd0, 2'd0);
    repeat (16) cyc();
    checks++; if (bus.pos !== 2'd2) $display("FAIL rt_pre got pos=%0d exp 2", bus.pos); else passes++;
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (bus.LED !== 4'b0001 || bus.pos !== 2'd0 || bus.step !== 1'b0)
      $display("FAIL rt_reset got led=%b pos=%0d step=%b exp led=0001 pos=0 step=0", bus.LED, bus.pos, bus.step);
    else passes++;
    repeat (7) cyc();
    checks++; if (bus.step !== 1'b0 || bus.LED !== 4'b0001)
      $display("FAIL rt_wait got step=%b led=%b exp step=0 led=0001", bus.step, bus.LED);
    else passes++;
    cyc();
    checks++; if (bus.step !== 1'b1 || bus.LED !== 4'b0010)
      $display("FAIL rt_first got step=%b led=%b exp step=1 led=0010", bus.step, bus.LED);
    else passes++;
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.mode   = 2'd0;
    bus.speed  = 2'd0;
    test_reset();
    test_up();
    test_down();
    test_bounce();
    test_blink();
    test_freeze();
    test_speed_change();
    test_reset_on_tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
# led_chaser

Parametrised LED pattern generator for the board's LED bank: a one-hot "chaser" that runs at a run-time selectable step rate and in one of four modes (shift up, shift down, bounce, blink-all). It sits between the board clock and the `LED` pins and is the generalised replacement for the fixed 16-LED, fixed-rate shifter. A one-cycle `step` pulse is exported so other logic can synchronise to pattern updates.

## Interface
- `NUM_LEDS`, 16: number of LEDs driven; legal range 2..64.
- `CLK_FREQ_HZ`, 100_000_000: frequency of `clk` in Hz.
- `STEP_MS`, 1000: base step period in ms at `speed` = 0.
- Derived `BASE_COUNT` = `CLK_FREQ_HZ`/1000*`STEP_MS`. It must be ≥ 8; elaboration fails otherwise.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: 1 = pattern advances; 0 = freeze (prescaler and position hold).
- `mode`, in, 2: 0 UP, 1 DOWN, 2 BOUNCE, 3 BLINK.
- `speed`, in, 2: step period = `BASE_COUNT` >> `speed` cycles (×1, ×2, ×4, ×8 faster).
- `LED`, out, `NUM_LEDS`: registered LED drive.
- `pos`, out, max(1,$clog2(`NUM_LEDS`)): current lit index.
- `step`, out, 1: registered one-cycle pulse marking a pattern update.

## Operation
- Prescaler `cnt`, width $clog2(`BASE_COUNT`), with P = `BASE_COUNT` >> `speed`.
  - Tick when `enable` && `cnt` ≥ P-1; on a tick, `cnt` ← 0.
  - Else if `enable`, `cnt` ← `cnt`+1. Else `cnt` holds.
  - Using ≥ means that lowering P mid-count ticks on the next enabled cycle. There is no overflow and no stall.
- Direction register `dir` (0 = up).
- On each tick, by `mode`:
  - UP: `pos` ← (`pos` == N-1) ? 0 : `pos`+1; `dir` ← 0.
  - DOWN: `pos` ← (`pos` == 0) ? N-1 : `pos`-1; `dir` ← 1.
  - BOUNCE, going up: at N-1, `dir` ← 1 and `pos` ← N-2; otherwise `pos`+1.
  - BOUNCE, going down: at 0, `dir` ← 0 and `pos` ← 1; otherwise `pos`-1. Endpoints are lit for exactly one step. Entering BOUNCE continues in the current `dir`.
  - BLINK: `pos` and `dir` hold; `blink_on` toggles.
- `blink_on` is forced to 1 on every cycle where `mode` ≠ 3, so BLINK always starts with all LEDs on.
- Next-state LED value: `mode` == 3 ? {N{`blink_on`}} : one-hot(`pos`). `LED` registers this every cycle, including when `enable` = 0.
  - A mode change is therefore visible on `LED` one cycle later, even while frozen.
- `step` ← tick (registered).
- Reset values: `cnt` = 0, `pos` = 0, `dir` = 0, `blink_on` = 1, `LED` = one-hot bit 0 (LED[0] = 1, all others 0), `step` = 0.
- Reset mid-operation overrides everything on that edge, including a coincident tick.
- Reset is the only way to re-zero the prescaler. Changing `mode` or `speed` never clears `cnt`.

## Timing
- With `enable` held high and `speed` constant, ticks occur every P cycles.
  - The first tick after reset is on the P-th enabled rising edge.
- `pos`, `LED` and `step` all update on the tick edge itself. `step` is high for exactly the one following cycle.
- `LED`/`pos` latency from a tick: 0 extra cycles. Latency from a `mode` change with no tick: 1 cycle.
- `enable` falling on the same cycle that would tick: no tick. `cnt` resumes from its held value when `enable` rises.
- `speed` change takes effect on the next compare. With `mode` change and tick in the same cycle, the tick uses the new `mode`.
- Minimum step period is `BASE_COUNT`>>3 ≥ 1 cycle, so a tick every cycle is legal. At that rate `step` stays high continuously.

## Test plan
Bench parameters: `NUM_LEDS`=4, `CLK_FREQ_HZ`=8000, `STEP_MS`=1, so `BASE_COUNT`=8.
- Reset, `mode`=0, `speed`=0, `enable`=1 -> `LED` = 0001. `LED` then reads 0010, 0100, 1000, 0001 at 8-cycle intervals, with `step` high one cycle at each change and `pos` 1, 2, 3, 0.
- `mode`=1, `speed`=2 (P=2) from reset -> `LED` 1000, 0100, 0010, 0001, 1000 every 2 cycles (wrap 0→3).
- `mode`=2, `speed`=3 (P=1) -> `pos` sequence 1, 2, 3, 2, 1, 0, 1, 2 on consecutive cycles. `step` is continuously high.
- `mode`=3, `speed`=0 -> `LED` = 1111 one cycle after the mode change. It then alternates 0000/1111 every 8 cycles, with `pos` unchanged. Return to `mode`=0 -> one-hot(`pos`) one cycle later.
- `enable` dropped for 20 cycles mid-count at `cnt`=5, `speed`=0 -> no `step`, `LED` frozen. The next tick comes 3 cycles after `enable` returns high.
- `rst` asserted on the same cycle as a tick with `pos`=2 -> next `LED` = 0001, `pos` = 0, `step` = 0, `cnt` = 0. The first tick comes 8 cycles after `rst` falls.
